// File: rtl/mc_rd_pack_ctrl_pkg.sv
// Shared types and constants for the memory-controller read-packing sequencer.
// Bus-width codes match the controller-wide csc[5:4] encoding.
package mc_rd_pack_ctrl_pkg;

  localparam logic [1:0] MC_BW_8  = 2'd0;
  localparam logic [1:0] MC_BW_16 = 2'd1;
  localparam logic [1:0] MC_BW_32 = 2'd2;

  typedef enum logic {
    MC_PK_IDLE = 1'b0,
    MC_PK_RUN  = 1'b1
  } mc_pk_state_e;

  // Byte offset presented to narrow devices for a given beat; reserved width 3 acts as 32-bit
  function automatic logic [1:0] pk_adr_lsb(input logic [1:0] bw, input logic [1:0] cnt);
    logic [1:0] a;
    a = 2'b00;
    if (bw == MC_BW_8)       a = cnt;
    else if (bw == MC_BW_16) a = {cnt[0], 1'b0};
    return a;
  endfunction

endpackage

// File: rtl/mc_rd_beat_cnt.sv
// Beat counter within one assembled word: tracks the beat index, flags the
// final beat for the current bus width and decodes the pack latch enables.
module mc_rd_beat_cnt
  import mc_rd_pack_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] bw,
  input  logic       beat_en,
  output logic [1:0] cnt_nxt,
  output logic       last_beat,
  output logic       pack_le0,
  output logic       pack_le1,
  output logic       pack_le2
);

  logic [1:0] cnt;
  logic       is8, is16;

  assign is8  = (bw == MC_BW_8);
  assign is16 = (bw == MC_BW_16);

  always_comb begin
    last_beat = 1'b1;
    if (is8)       last_beat = (cnt == 2'd3);
    else if (is16) last_beat = cnt[0];
  end

  always_comb begin
    cnt_nxt = cnt;
    if (clr)          cnt_nxt = 2'd0;
    else if (beat_en) cnt_nxt = last_beat ? 2'd0 : cnt + 2'd1;
  end

  assign pack_le0 = beat_en & ((is8 & (cnt == 2'd0)) | (is16 & ~cnt[0]));
  assign pack_le1 = beat_en & is8 & (cnt == 2'd1);
  assign pack_le2 = beat_en & is8 & (cnt == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 2'd0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/mc_rd_pack_ctrl.sv
// Read-packing sequencer: runs a multi-word read burst, driving pack latch
// enables and word-valid to mc_dp with zero latency from the beat strobe.
module mc_rd_pack_ctrl
  import mc_rd_pack_ctrl_pkg::*;
#(
  parameter int WCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    csc,
  input  logic           rd_start,
  input  logic [WCW-1:0] rd_words,
  input  logic           beat_v,
  input  logic           abort,
  output logic           pack_le0,
  output logic           pack_le1,
  output logic           pack_le2,
  output logic           dv,
  output logic [1:0]     adr_lsb,
  output logic           busy,
  output logic           done
);

  mc_pk_state_e   state, state_nxt;
  logic [1:0]     bw_q;
  logic [WCW-1:0] words_left;
  logic [1:0]     cnt_nxt;
  logic           start, beat_en, last_beat, last_word;
  logic           unused_csc;

  assign unused_csc = ^{csc[31:6], csc[3:0]};

  assign start     = (state == MC_PK_IDLE) & rd_start;
  assign beat_en   = (state == MC_PK_RUN) & beat_v & ~abort;
  assign last_word = (words_left == WCW'(1));
  assign dv        = beat_en & last_beat;
  assign busy      = (state == MC_PK_RUN);

  mc_rd_beat_cnt u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .bw       (bw_q),
    .beat_en  (beat_en),
    .cnt_nxt  (cnt_nxt),
    .last_beat(last_beat),
    .pack_le0 (pack_le0),
    .pack_le1 (pack_le1),
    .pack_le2 (pack_le2)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      MC_PK_IDLE: if (rd_start) state_nxt = MC_PK_RUN;
      MC_PK_RUN:  if (abort || (dv && last_word)) state_nxt = MC_PK_IDLE;
      default:    state_nxt = MC_PK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MC_PK_IDLE;
      bw_q       <= MC_BW_32;
      words_left <= '0;
      done       <= 1'b0;
      adr_lsb    <= 2'b00;
    end else begin
      state   <= state_nxt;
      done    <= dv & last_word;
      // Tracks the counter's next value so the offset lines up with the beat it addresses
      adr_lsb <= pk_adr_lsb(bw_q, cnt_nxt);
      if (start) begin
        bw_q       <= csc[5:4];
        words_left <= (rd_words == '0) ? WCW'(1) : rd_words;
      end else if (dv) begin
        words_left <= words_left - WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_rd_pack_ctrl.sv
// Directed bench for mc_rd_pack_ctrl: per-cycle vector table plus hand-written
// reset-mid-burst and long-burst sequences.
module tb_mc_rd_pack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [31:0] csc;
  logic       rd_start;
  logic [7:0] rd_words;
  logic       beat_v, abort;
  logic       pack_le0, pack_le1, pack_le2, dv;
  logic [1:0] adr_lsb;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  mc_rd_pack_ctrl #(.WCW(8)) dut (
    .clk(clk), .rst(rst), .csc(csc), .rd_start(rd_start), .rd_words(rd_words),
    .beat_v(beat_v), .abort(abort), .pack_le0(pack_le0), .pack_le1(pack_le1),
    .pack_le2(pack_le2), .dv(dv), .adr_lsb(adr_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] wd;
    logic [1:0] bw;
    logic       bv;
    logic       ab;
    logic [3:0] pk;   // {pack_le0, pack_le1, pack_le2, dv}
    logic [1:0] adr;
    logic       chk_adr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic st, input logic [7:0] wd, input logic [1:0] bw,
                     input logic bv, input logic ab, input logic [3:0] pk,
                     input logic [1:0] adr, input logic ca, input logic b, input logic d);
    vec_t v;
    v.st = st; v.wd = wd; v.bw = bw; v.bv = bv; v.ab = ab;
    v.pk = pk; v.adr = adr; v.chk_adr = ca; v.busy = b; v.done = d;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] wd, input logic [1:0] bw,
                       input logic bv, input logic ab);
    rd_start = st;
    rd_words = wd;
    csc      = {26'h2AAAAAA, bw, 4'hF};
    beat_v   = bv;
    abort    = ab;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] pk, input logic [1:0] adr,
                         input logic ca, input logic b, input logic d);
    chk({tag, " pack/dv"}, {pack_le0, pack_le1, pack_le2, dv}, pk);
    if (ca) chk({tag, " adr_lsb"}, adr_lsb, adr);
    chk({tag, " busy"}, busy, b);
    chk({tag, " done"}, done, d);
  endtask

  initial begin
    int ndv;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 8-bit single word
    add(1,1,0,0,0, 4'b0000,0,1,0,0);
    add(0,0,0,1,0, 4'b1000,0,1,1,0);
    add(0,0,0,1,0, 4'b0100,1,1,1,0);
    add(0,0,0,1,0, 4'b0010,2,1,1,0);
    add(0,0,0,1,0, 4'b0001,3,1,1,0);
    add(0,0,0,0,0, 4'b0000,0,1,0,1);
    add(0,0,0,0,0, 4'b0000,0,1,0,0);
    // 16-bit, three words back to back
    add(1,3,1,0,0, 4'b0000,0,1,0,0);
    for (int i = 0; i < 3; i++) begin
      add(0,0,1,1,0, 4'b1000,0,1,1,0);
      add(0,0,1,1,0, 4'b0001,2,1,1,0);
    end
    add(0,0,1,0,0, 4'b0000,0,1,0,1);
    // 32-bit, rd_words=0 acts as one word; trailing beats ignored
    add(1,0,2,0,0, 4'b0000,0,1,0,0);
    add(0,0,2,1,0, 4'b0001,0,1,1,0);
    add(0,0,2,1,0, 4'b0000,0,1,0,1);
    add(0,0,2,1,0, 4'b0000,0,1,0,0);
    // 8-bit, two words, abort on the 6th beat
    add(1,2,0,0,0, 4'b0000,0,1,0,0);
    add(0,0,0,1,0, 4'b1000,0,1,1,0);
    add(0,0,0,1,0, 4'b0100,1,1,1,0);
    add(0,0,0,1,0, 4'b0010,2,1,1,0);
    add(0,0,0,1,0, 4'b0001,3,1,1,0);
    add(0,0,0,1,0, 4'b1000,0,1,1,0);
    add(0,0,0,1,1, 4'b0000,1,1,1,0);
    add(0,0,0,0,0, 4'b0000,0,0,0,0);
    add(1,1,0,0,0, 4'b0000,0,0,0,0);
    add(0,0,0,1,0, 4'b1000,0,1,1,0);
    add(0,0,0,1,0, 4'b0100,1,1,1,0);
    add(0,0,0,1,0, 4'b0010,2,1,1,0);
    add(0,0,0,1,0, 4'b0001,3,1,1,0);
    add(0,0,0,0,0, 4'b0000,0,1,0,1);
    // abort and beat in IDLE do nothing
    add(0,0,0,1,1, 4'b0000,0,1,0,0);
    // csc switched to 32-bit mid-burst, extra rd_start in RUN ignored
    add(1,1,0,0,0, 4'b0000,0,1,0,0);
    add(1,5,2,1,0, 4'b1000,0,1,1,0);
    add(1,5,2,1,0, 4'b0100,1,1,1,0);
    add(0,0,2,1,0, 4'b0010,2,1,1,0);
    add(0,0,2,1,0, 4'b0001,3,1,1,0);
    // rd_start coincident with done is accepted (now 32-bit)
    add(1,1,2,0,0, 4'b0000,0,1,0,1);
    add(0,0,2,1,0, 4'b0001,0,1,1,0);
    add(0,0,2,0,0, 4'b0000,0,1,0,1);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].st, vt[i].wd, vt[i].bw, vt[i].bv, vt[i].ab);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].pk, vt[i].adr, vt[i].chk_adr, vt[i].busy, vt[i].done);
    end

    // asynchronous reset after two beats of an 8-bit word
    @(negedge clk); drive(1, 1, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1 chk_all("rst_mid", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 0); #1 chk_all("post_rst0", 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #1 chk_all("post_rst1", 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #1 chk_all("post_rst2", 4'b0010, 2'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #1 chk_all("post_rst3", 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive(0, 0, 0, 0, 0); #1 chk_all("post_rst_done", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1);

    // 255-word 32-bit burst: no wrap, busy through the last word
    @(negedge clk); drive(1, 8'd255, 2, 0, 0);
    ndv = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk); drive(0, 0, 2, 1, 0);
      #1;
      if (dv) ndv++;
      if (i == 254) chk("long busy_last", busy, 1'b1);
    end
    @(negedge clk); drive(0, 0, 2, 0, 0);
    #1;
    chk("long dv_count", ndv, 255);
    chk("long done", done, 1'b1);
    chk("long busy_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_rd_pack_ctrl.md
# mc_rd_pack_ctrl

Read-packing sequencer for the memory controller data path. It counts memory read beats for the word being assembled and produces the pack latch enables (`pack_le0/1/2`) and word-valid strobe (`dv`) consumed by `mc_dp`. It also drives the byte/halfword address offset for narrow (8/16-bit) devices and tracks a multi-word read burst from start to completion or abort. It sits between the memory timing FSM, which supplies beat strobes, and `mc_dp`.

## Interface
Parameters:
- `WCW`, 8: width of the word-count field.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `csc`  in  32  chip-select config; only `csc[5:4]` (bus width) is used.
- `rd_start`  in  1  single-cycle pulse; starts a burst of `rd_words` words.
- `rd_words`  in  WCW  words in the burst, sampled with `rd_start`; 0 is treated as 1.
- `beat_v`  in  1  memory beat strobe; `mc_data_del` is valid this cycle.
- `abort`  in  1  kill the burst (WB cycle dropped or write started).
- `pack_le0`, `pack_le1`, `pack_le2`  out  1 each  pack latch enables to `mc_dp`.
- `dv`  out  1  assembled word valid (read FIFO write enable).
- `adr_lsb`  out  2  address offset of the current beat.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse after the last `dv` of a burst.

## Operation
- Bus width `bw = csc[5:4]` is latched at `rd_start`. Values: `MC_BW_8`=0, `MC_BW_16`=1, `MC_BW_32`=2. The reserved value 3 behaves as 32-bit.
- States:
  - IDLE: `rd_start` loads `words_left = max(rd_words,1)`, clears `beat_cnt`, latches `bw`, and moves to RUN.
  - RUN: runs until the last word or `abort`, then returns to IDLE.
- Beats per word: 4 (8-bit), 2 (16-bit), 1 (32-bit). `beat_cnt` is 2 bits.
- Decoded outputs, combinational from registered state, valid only in RUN with `beat_v=1` and `abort=0`:
  - 8-bit: `pack_le0` at cnt 0, `pack_le1` at cnt 1, `pack_le2` at cnt 2, `dv` at cnt 3.
  - 16-bit: `pack_le0` at cnt 0, `dv` at cnt 1.
  - 32-bit: `dv` on every beat.
- A qualified beat increments `beat_cnt`. The final beat of a word clears `beat_cnt` and decrements `words_left`. When `words_left` reaches 0 on that beat, the block goes to IDLE and `done` is set for the next cycle.
- `adr_lsb` (registered): 8-bit gives `beat_cnt`; 16-bit gives `{beat_cnt[0],1'b0}`; 32-bit gives `2'b00`.
- `busy` = (state == RUN).

## Timing
- Reset values:
  - state IDLE; `beat_cnt`=0, `words_left`=0, `bw`=`MC_BW_32`.
  - `busy`=0, `done`=0, `adr_lsb`=0.
  - `pack_le*`=0, `dv`=0.
- `rd_start` at cycle n gives `busy`=1 at n+1. The first qualified beat can occur at n+1.
- `pack_le*` and `dv` have zero latency: they are asserted in the same cycle as `beat_v`, so `mc_dp` sees the final byte live on `mc_data_del`.
- `done` is asserted exactly one cycle after the final `dv`, for one cycle. `busy` drops in that same cycle.
- Boundary cases:
  - `beat_v` in IDLE: ignored, no outputs.
  - `rd_start` while RUN: ignored; the burst is not restarted.
  - `abort` with `beat_v` in the same cycle: `abort` wins. No `pack_le`/`dv`, IDLE next cycle, no `done`.
  - `abort` in IDLE: no effect.
  - `rd_start` in the same cycle as `done`: accepted, since state is already IDLE.
  - `rd_words`=0: one-word burst.
  - `rd_words`=255 (`WCW`=8): 255 words, no wrap.
  - `csc` changing mid-burst: no effect until the next `rd_start`.
  - `rst` mid-burst: immediate return to reset values; a partially packed word is dropped.

## Structure
- `MC_BW_8/16/32` already live in the shared `mc_defines.v`; use them, do not redefine.
- State encoding (`MC_PK_IDLE`, `MC_PK_RUN`) is local to the block.
- One natural sub-module: `mc_rd_beat_cnt`, a 2-bit beat counter. It takes inputs `bw` and a qualified-beat enable, and produces `last_beat` plus the decoded `pack_le0..2`. The top keeps the FSM, word counter, `adr_lsb` and `done`.

## Test plan
- 8-bit, `rd_words`=1, four `beat_v` pulses → `pack_le0`, `pack_le1`, `pack_le2`, then `dv`; `adr_lsb` = 0, 1, 2, 3; `done` one cycle after `dv`.
- 16-bit, `rd_words`=3, six consecutive beats → `pack_le0`/`dv` alternating (3 `dv` total); `adr_lsb` = 0, 2, 0, 2, 0, 2; `busy` for exactly the burst.
- 32-bit, `rd_words`=0 → a single beat gives one `dv`, then `done`; a further `beat_v` gives no output.
- 8-bit, `rd_words`=2, `abort` together with the 6th beat → no `dv` on that beat, IDLE next cycle, no `done`; a new `rd_start` afterwards restarts at `adr_lsb`=0.
- `rst` asserted asynchronously after 2 beats of an 8-bit word → all outputs 0 immediately; after release, a fresh burst packs correctly from `pack_le0`.
- `csc` bus width switched from 8 to 32 mid-burst, plus `rd_start` pulsed during RUN → sequence continues 8-bit and the extra start is ignored.
